fu_alu_exec_unit: RTL and testbench
===================================

// Module: fu_alu_exec_unit
// PURPOSE
//  Consumer end of the issue-table -> FU issue interface. Takes one issued ALU instruction per cycle,
//  executes it through a fixed LAT_P-stage pipeline, and broadcasts the result on its own CDB slot.
//  Also pushes {rob_dest, result, flags} into a result FIFO that the ROB drains via valid/ready.
//  Has no input backpressure; it advertises a credit-style ready_o for the issue stage.
// PARAMETERS
//  WORD_SIZE_P   16  operand/result width
//  TAG_W_P        6  phys-reg tag width ($clog2(NUM_PHYS_REG))
//  ROB_W_P        5  ROB index width
//  LAT_P          2  execute pipeline depth in cycles, >=1
//  FIFO_DEPTH_P   4  result FIFO entries, power of 2, >= 2
// PORTS
//  clk_i          in   1        clock
//  reset_n_i      in   1        async active-low reset
//  issue_v_i      in   1        issued instruction valid, this FU's valid_o bit
//  opcode_i       in   3        0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR(logical),7 PASS src2
//  src1_i         in   WORD     source 1 data
//  src2_i         in   WORD     source 2 / immediate data
//  dest_i         in   TAG_W    destination phys tag
//  w_v_i          in   1        instruction writes a register
//  rob_dest_i     in   ROB_W    ROB slot
//  ready_o        out  1        credit: safe to issue next cycle
//  cdb_valid_o    out  1        CDB slot valid, one cycle per result with w_v
//  cdb_dest_o     out  TAG_W    CDB tag
//  cdb_result_o   out  WORD     CDB data
//  rob_v_o        out  1        result FIFO head valid
//  rob_ready_i    in   1        ROB accepts head
//  rob_dest_o     out  ROB_W    head ROB slot
//  rob_result_o   out  WORD     head result
//  rob_flags_o    out  4        head flags {N,Z,C,V}
//  overflow_o     out  1        sticky: issue accepted with no credit
// BEHAVIOUR
//  Reset (async assert, sync deassert usage): all pipe valids, FIFO pointers and count are 0;
//   ready_o=1, cdb_valid_o=0, rob_v_o=0, overflow_o=0; data outputs are 0.
//  Execute: result computed in stage 0 and carried through LAT_P registers; an issue in cycle t
//   appears on the CDB in cycle t+LAT_P and is written into the FIFO at the same edge.
//   It is visible on rob_* in cycle t+LAT_P+1 when the FIFO was empty.
//  Arithmetic: ADD/SUB are WORD_SIZE_P-bit modulo. C = carry out for ADD and NOT borrow for SUB.
//   V = signed overflow for ADD/SUB. C = last bit shifted out for SHL/SHR; shift amount is
//   src2[$clog2(WORD)-1:0]. C=V=0 for logic ops/PASS. N = result MSB, Z = (result==0).
//  CDB: cdb_valid_o = pipe-out valid & w_v; dest/result are driven from the pipe-out regs;
//   result is 0 when not valid. The CDB is never stalled.
//  FIFO: push = pipe-out valid (all instrs incl. w_v=0, for ROB completion); pop = rob_v_o & rob_ready_i.
//   Simultaneous push+pop is legal when full and count is unchanged. Pointers wrap modulo FIFO_DEPTH_P.
//  Credit: occ = fifo_count + inflight (# valid pipe stages incl. this-cycle issue).
//   ready_o is registered: 1 when next-cycle occ + LAT_P < FIFO_DEPTH_P, counting a pop in the same cycle.
//  Overflow: issue_v_i while ready_o=0 still executes. If push hits a full FIFO without pop, the
//   push is dropped and overflow_o sets and holds until reset. The CDB broadcast still occurs.
//  Reset mid-operation flushes the pipe and FIFO immediately; no CDB pulse is emitted for flushed entries.
// TESTING
//  1 ADD 0x7FFF+0x0001, dest 5, rob 3 at t -> cdb_valid at t+2, dest 5, 0x8000; rob head flags N=1,V=1,C=0,Z=0.
//  2 SUB 0x0003-0x0003 w_v=0 -> no CDB pulse; FIFO entry result 0, Z=1, C=1.
//  3 rob_ready_i=0, issue back-to-back while ready_o=1 -> ready_o drops so occ never exceeds 4.
//    No overflow; drain yields results in issue order.
//  4 FIFO full, forced issue with ready_o=0, no pop -> overflow_o=1 sticky; CDB still pulses; FIFO contents intact.
//  5 SHL 0x8001 by 1 -> 0x0002, C=1; SHR 0x0001 by 1 -> 0x0000, Z=1, C=1.
//  6 reset_n_i low with 2 in flight and 3 queued -> outputs zero at once, ready_o=1; post-release pulses none.

Source files
------------

// File: rtl/fu_alu_exec_unit.sv
// ALU functional unit: fixed-latency execute pipe, CDB broadcast and a result FIFO toward the ROB.
// ready_o is a registered credit computed from FIFO occupancy plus instructions in flight.
module fu_alu_exec_unit #(
  parameter int unsigned WORD_SIZE_P  = 16,
  parameter int unsigned TAG_W_P      = 6,
  parameter int unsigned ROB_W_P      = 5,
  parameter int unsigned LAT_P        = 2,
  parameter int unsigned FIFO_DEPTH_P = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   issue_v_i,
  input  logic [2:0]             opcode_i,
  input  logic [WORD_SIZE_P-1:0] src1_i,
  input  logic [WORD_SIZE_P-1:0] src2_i,
  input  logic [TAG_W_P-1:0]     dest_i,
  input  logic                   w_v_i,
  input  logic [ROB_W_P-1:0]     rob_dest_i,
  output logic                   ready_o,
  output logic                   cdb_valid_o,
  output logic [TAG_W_P-1:0]     cdb_dest_o,
  output logic [WORD_SIZE_P-1:0] cdb_result_o,
  output logic                   rob_v_o,
  input  logic                   rob_ready_i,
  output logic [ROB_W_P-1:0]     rob_dest_o,
  output logic [WORD_SIZE_P-1:0] rob_result_o,
  output logic [3:0]             rob_flags_o,
  output logic                   overflow_o
);

  localparam int unsigned Msb   = WORD_SIZE_P - 1;
  localparam int unsigned ShW   = $clog2(WORD_SIZE_P);
  localparam int unsigned EntW  = ROB_W_P + WORD_SIZE_P + 4;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH_P);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH_P + 1);
  localparam int unsigned Last  = LAT_P - 1;

  // ---------------- ALU (stage 0) ----------------
  logic [ShW-1:0]         shamt;
  logic [WORD_SIZE_P:0]   add_w, sub_w, shl_w, shr_w;
  logic [WORD_SIZE_P-1:0] alu_res;
  logic                   alu_c, alu_v;
  logic [3:0]             alu_flags;

  assign shamt = src2_i[ShW-1:0];

  always_comb begin
    add_w   = {1'b0, src1_i} + {1'b0, src2_i};
    sub_w   = {1'b0, src1_i} - {1'b0, src2_i};
    // One spare bit on each side catches the last bit shifted out
    shl_w   = {1'b0, src1_i} << shamt;
    shr_w   = {src1_i, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode_i)
      3'd0: begin
        alu_res = add_w[Msb:0];
        alu_c   = add_w[WORD_SIZE_P];
        alu_v   = (src1_i[Msb] == src2_i[Msb]) & (alu_res[Msb] ^ src1_i[Msb]);
      end
      3'd1: begin
        alu_res = sub_w[Msb:0];
        alu_c   = ~sub_w[WORD_SIZE_P];
        alu_v   = (src1_i[Msb] ^ src2_i[Msb]) & (alu_res[Msb] ^ src1_i[Msb]);
      end
      3'd2: alu_res = src1_i & src2_i;
      3'd3: alu_res = src1_i | src2_i;
      3'd4: alu_res = src1_i ^ src2_i;
      3'd5: begin
        alu_res = shl_w[Msb:0];
        alu_c   = shl_w[WORD_SIZE_P];
      end
      3'd6: begin
        alu_res = shr_w[WORD_SIZE_P:1];
        alu_c   = shr_w[0];
      end
      default: alu_res = src2_i;
    endcase
    alu_flags = {alu_res[Msb], alu_res == '0, alu_c, alu_v};
  end

  // ---------------- pipeline and FIFO state ----------------
  logic [LAT_P-1:0]   pv_q, pw_q;
  logic [TAG_W_P-1:0] pdest_q [LAT_P];
  logic [EntW-1:0]    pent_q  [LAT_P];

  logic [EntW-1:0]    mem_q [FIFO_DEPTH_P];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;

  logic               out_v, push, pop, full, do_push;
  logic [31:0]        inflight_d;
  logic [EntW-1:0]    head;

  assign out_v   = pv_q[Last];
  assign push    = out_v;
  assign pop     = rob_v_o & rob_ready_i;
  assign full    = (count_q == CntW'(FIFO_DEPTH_P));
  assign do_push = push & (~full | pop);

  always_comb begin
    count_d    = count_q + CntW'(do_push) - CntW'(pop);
    overflow_d = overflow_q | (push & full & ~pop);
    // Valid stages after the edge: this-cycle issue plus everything not leaving the pipe
    inflight_d = 32'(issue_v_i);
    for (int unsigned i = 1; i < LAT_P; i++) begin
      inflight_d = inflight_d + 32'(pv_q[i-1]);
    end
    ready_d = (32'(count_d) + inflight_d + LAT_P) < FIFO_DEPTH_P;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pv_q <= '0;
      pw_q <= '0;
      for (int unsigned i = 0; i < LAT_P; i++) begin
        pdest_q[i] <= '0;
        pent_q[i]  <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH_P; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      pv_q[0]    <= issue_v_i;
      pw_q[0]    <= w_v_i;
      pdest_q[0] <= dest_i;
      pent_q[0]  <= {rob_dest_i, alu_res, alu_flags};
      for (int unsigned i = 1; i < LAT_P; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pw_q[i]    <= pw_q[i-1];
        pdest_q[i] <= pdest_q[i-1];
        pent_q[i]  <= pent_q[i-1];
      end
      if (do_push) begin
        mem_q[wr_ptr_q] <= pent_q[Last];
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------- outputs ----------------
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    cdb_valid_o  = out_v & pw_q[Last];
    cdb_dest_o   = cdb_valid_o ? pdest_q[Last] : '0;
    cdb_result_o = cdb_valid_o ? pent_q[Last][WORD_SIZE_P+3:4] : '0;
    rob_v_o      = (count_q != '0);
    rob_dest_o   = rob_v_o ? head[EntW-1:WORD_SIZE_P+4] : '0;
    rob_result_o = rob_v_o ? head[WORD_SIZE_P+3:4] : '0;
    rob_flags_o  = rob_v_o ? head[3:0] : '0;
  end

  assign ready_o    = ready_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fu_alu_exec_unit.sv
// Randomized bench for fu_alu_exec_unit against a queue-based transaction model.
module tb_fu_alu_exec_unit;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        issue_v_i, w_v_i, rob_ready_i;
  logic [2:0]  opcode_i;
  logic [15:0] src1_i, src2_i;
  logic [5:0]  dest_i;
  logic [4:0]  rob_dest_i;
  logic        ready_o, cdb_valid_o, rob_v_o, overflow_o;
  logic [5:0]  cdb_dest_o;
  logic [15:0] cdb_result_o, rob_result_o;
  logic [4:0]  rob_dest_o;
  logic [3:0]  rob_flags_o;

  fu_alu_exec_unit dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .issue_v_i    (issue_v_i),
    .opcode_i     (opcode_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .dest_i       (dest_i),
    .w_v_i        (w_v_i),
    .rob_dest_i   (rob_dest_i),
    .ready_o      (ready_o),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_dest_o   (cdb_dest_o),
    .cdb_result_o (cdb_result_o),
    .rob_v_o      (rob_v_o),
    .rob_ready_i  (rob_ready_i),
    .rob_dest_o   (rob_dest_o),
    .rob_result_o (rob_result_o),
    .rob_flags_o  (rob_flags_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int        due;
    bit        wv;
    bit [5:0]  dest;
    bit [4:0]  rob;
    bit [15:0] res;
    bit [3:0]  flags;
  } ent_t;

  ent_t pq[$];   // issued, not yet at pipe output
  ent_t fq[$];   // result FIFO contents
  bit   exp_ready = 1'b1;
  bit   exp_ovf   = 1'b0;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void alu_ref(input bit [2:0] op, input int unsigned a, input int unsigned b,
                                  output bit [15:0] r, output bit [3:0] f);
    int unsigned sh = b % 16;
    int sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    int sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    int unsigned s;
    bit c = 0, v = 0;
    case (op)
      0: begin
        s = a + b; r = 16'(s); c = (s >= 65536);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      1: begin
        r = 16'(a - b); c = (a >= b);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      2: r = 16'(a & b);
      3: r = 16'(a | b);
      4: r = 16'(a ^ b);
      5: begin r = 16'(a << sh); c = (sh != 0) && (((a >> (16 - sh)) & 1) == 1); end
      6: begin r = 16'(a >> sh); c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      default: r = 16'(b);
    endcase
    f = {r[15], r == 16'd0, c, v};
  endfunction

  task automatic check_outputs();
    bit cv = 1'b0;
    if (pq.size() > 0) begin
      if (pq[0].due == cyc && pq[0].wv) cv = 1'b1;
    end
    check_eq("ready", ready_o, exp_ready);
    check_eq("cdb_valid", cdb_valid_o, cv);
    if (cv) begin
      check_eq("cdb_dest", cdb_dest_o, pq[0].dest);
      check_eq("cdb_result", cdb_result_o, pq[0].res);
    end else begin
      check_eq("cdb_result_idle", cdb_result_o, 0);
    end
    check_eq("rob_v", rob_v_o, fq.size() != 0);
    if (fq.size() != 0) begin
      check_eq("rob_dest", rob_dest_o, fq[0].rob);
      check_eq("rob_result", rob_result_o, fq[0].res);
      check_eq("rob_flags", rob_flags_o, fq[0].flags);
    end
    check_eq("overflow", overflow_o, exp_ovf);
  endtask

  task automatic do_cycle(input bit iv, input bit [2:0] op, input bit [15:0] a, input bit [15:0] b,
                          input bit [5:0] d, input bit wv, input bit [4:0] rb, input bit rr);
    ent_t e;
    @(negedge clk_i);
    check_outputs();
    issue_v_i = iv; opcode_i = op; src1_i = a; src2_i = b;
    dest_i = d; w_v_i = wv; rob_dest_i = rb; rob_ready_i = rr;
    if (rr && fq.size() > 0) void'(fq.pop_front());
    if (pq.size() > 0) begin
      if (pq[0].due == cyc) begin
        e = pq.pop_front();
        if (fq.size() < Depth) fq.push_back(e);
        else exp_ovf = 1'b1;
      end
    end
    if (iv) begin
      e.due = cyc + Lat; e.wv = wv; e.dest = d; e.rob = rb;
      alu_ref(op, a, b, e.res, e.flags);
      pq.push_back(e);
    end
    exp_ready = (fq.size() + pq.size() + Lat) < Depth;
    cyc++;
  endtask

  task automatic idle(input bit rr);
    do_cycle(1'b0, 3'd0, 16'd0, 16'd0, 6'd0, 1'b0, 5'd0, rr);
  endtask

  task automatic rand_cycle(input bit force_iv, input bit rr);
    bit iv = force_iv || (exp_ready && ($urandom_range(0, 3) != 0));
    do_cycle(iv, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 6'($urandom),
             $urandom_range(0, 3) != 0, 5'($urandom), rr);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    issue_v_i = 1'b0; rob_ready_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_eq("rst_cdb_valid", cdb_valid_o, 0);
    check_eq("rst_cdb_dest", cdb_dest_o, 0);
    check_eq("rst_cdb_result", cdb_result_o, 0);
    check_eq("rst_rob_v", rob_v_o, 0);
    check_eq("rst_rob_dest", rob_dest_o, 0);
    check_eq("rst_rob_result", rob_result_o, 0);
    check_eq("rst_rob_flags", rob_flags_o, 0);
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_overflow", overflow_o, 0);
    pq.delete(); fq.delete();
    exp_ovf = 1'b0; exp_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    issue_v_i = 0; opcode_i = 0; src1_i = 0; src2_i = 0; dest_i = 0;
    w_v_i = 0; rob_dest_i = 0; rob_ready_i = 0;
    do_reset();

    // Directed: ADD overflow, SUB to zero without write, shifts with carry-out
    do_cycle(1, 3'd0, 16'h7FFF, 16'h0001, 6'd5, 1, 5'd3, 1);
    repeat (3) idle(1);
    do_cycle(1, 3'd1, 16'h0003, 16'h0003, 6'd7, 0, 5'd4, 1);
    repeat (3) idle(1);
    do_cycle(1, 3'd5, 16'h8001, 16'h0001, 6'd9, 1, 5'd5, 1);
    repeat (3) idle(1);
    do_cycle(1, 3'd6, 16'h0001, 16'h0001, 6'd10, 1, 5'd6, 1);
    repeat (4) idle(1);

    // Credit-limited issue with the ROB stalled, then drain
    repeat (12) rand_cycle(0, 0);
    repeat (10) idle(1);

    repeat (300) rand_cycle(0, $urandom_range(0, 3) != 0);
    repeat (10) idle(1);

    // Forced issue past the credit with no pops: last push is dropped
    repeat (5) rand_cycle(1, 0);
    repeat (4) idle(0);
    repeat (8) idle(1);

    // Reset with instructions both queued and in flight
    repeat (8) idle(1);
    repeat (5) rand_cycle(1, 0);
    do_reset();
    repeat (6) idle(1);

    repeat (100) rand_cycle(0, $urandom_range(0, 3) != 0);
    repeat (8) idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
